// File: rtl/alu_muldiv.sv
// Iterative signed multiply / divide unit: one shift-add or restoring
// shift-subtract step per clock on operand magnitudes, sign fix-up at the end.
module alu_muldiv #(
    parameter int REG_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op,
    input  logic [REG_DATA_WIDTH-1:0] operand_a,
    input  logic [REG_DATA_WIDTH-1:0] operand_b,
    output logic                      busy,
    output logic                      done,
    output logic [REG_DATA_WIDTH-1:0] result_hi,
    output logic [REG_DATA_WIDTH-1:0] result_lo,
    output logic                      div_by_zero
);
    localparam int W     = REG_DATA_WIDTH;
    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic             op_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     mag_b;
    logic             neg_res;
    logic             neg_rem;
    logic             b_zero;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     hi_reg;
    logic [W-1:0]     lo_reg;

    logic [W-1:0]     mag_a_in;
    logic [W-1:0]     mag_b_in;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             div_ok;
    logic [W-1:0]     step_hi;
    logic [W-1:0]     step_lo;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;
    logic [W-1:0]     fix_hi;
    logic [W-1:0]     fix_lo;

    always_comb begin
        // Negating the most-negative value yields 2^(W-1), exact as unsigned.
        mag_a_in  = operand_a[W-1] ? -operand_a : operand_a;
        mag_b_in  = operand_b[W-1] ? -operand_b : operand_b;

        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
        div_shift = {hi_reg, lo_reg[W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ok    = ~div_diff[W];

        if (op_reg) begin
            step_hi = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
            step_lo = {lo_reg[W-2:0], div_ok};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_reg[W-1:1]};
        end

        prod_fix = neg_res ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        quot_fix = neg_res ? -lo_reg : lo_reg;
        rem_fix  = neg_rem ? -hi_reg : hi_reg;

        if (!op_reg) begin
            fix_hi = prod_fix[2*W-1:W];
            fix_lo = prod_fix[W-1:0];
        end else if (b_zero) begin
            fix_hi = a_reg;
            fix_lo = {W{1'b1}};
        end else begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_reg      <= 1'b0;
            a_reg       <= '0;
            mag_b       <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            b_zero      <= 1'b0;
            count       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg  <= op;
                        a_reg   <= operand_a;
                        mag_b   <= mag_b_in;
                        neg_res <= operand_a[W-1] ^ operand_b[W-1];
                        neg_rem <= operand_a[W-1];
                        b_zero  <= (operand_b == '0);
                        count   <= '0;
                        hi_reg  <= '0;
                        lo_reg  <= mag_a_in;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    hi_reg <= step_hi;
                    lo_reg <= step_lo;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_hi   <= fix_hi;
                    result_lo   <= fix_lo;
                    div_by_zero <= op_reg & b_zero;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: cycle-level reference model with a
// per-cycle compare process plus directed vectors with literal expectations.
module tb_alu_muldiv;
    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_hi;
    logic [W-1:0]  result_lo;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.REG_DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain signed integer math.
    function automatic void model_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        int sa;
        int sb;
        longint p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        z  = 1'b0;
        if (!o) begin
            p = longint'(sa) * longint'(sb);
            h = 16'(p >>> 16);
            l = 16'(p);
        end else if (sb == 0) begin
            h = a;
            l = 16'hFFFF;
            z = 1'b1;
        end else begin
            l = 16'(sa / sb);
            h = 16'(sa % sb);
        end
    endfunction

    // Timeline model: an op accepted at edge T is busy for cycles T..T+W,
    // done in cycle T+W+1, and the unit accepts again from edge T+W+3.
    int          cycle_cnt = 0;
    bit          inflight  = 0;
    int          t_start   = 0;
    bit          cmp_en    = 0;
    logic [W-1:0] pend_hi, pend_lo, exp_hi, exp_lo;
    logic         pend_dbz, exp_dbz;

    initial begin
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        pend_hi = '0; pend_lo = '0; pend_dbz = 1'b0;
    end

    always @(posedge clk) begin
        cycle_cnt = cycle_cnt + 1;
        if (rst) begin
            if (inflight && cycle_cnt == t_start + W + 1) begin
                exp_hi  = pend_hi;
                exp_lo  = pend_lo;
                exp_dbz = pend_dbz;
            end
            if (start && (!inflight || cycle_cnt >= t_start + W + 3)) begin
                t_start  = cycle_cnt;
                inflight = 1;
                model_op(op, operand_a, operand_b, pend_hi, pend_lo, pend_dbz);
            end
        end
    end

    always @(negedge rst) begin
        inflight = 0;
        exp_hi   = '0;
        exp_lo   = '0;
        exp_dbz  = 1'b0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", busy, inflight && rst && cycle_cnt <= t_start + W);
            check("cmp_done", done, inflight && rst && cycle_cnt == t_start + W + 1);
            check("cmp_hi", result_hi, exp_hi);
            check("cmp_lo", result_lo, exp_lo);
            check("cmp_dbz", div_by_zero, exp_dbz);
        end
    end

    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xh, input logic [W-1:0] xl, input logic xz,
                         input bit inject);
        int  n;
        int  extra_done;
        bit  seen;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (inject && n == 5) begin
                start = 1'b1; op = 1'b1; operand_a = 16'h0007; operand_b = 16'h0003;
            end
            if (inject && n == 6) start = 1'b0;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", n, 18);
        check("lit_hi", result_hi, xh);
        check("lit_lo", result_lo, xl);
        check("lit_dbz", div_by_zero, xz);
        $display("%s a=%h b=%h -> hi=%h lo=%h dbz=%0d latency=%0d",
                 o ? "div" : "mul", a, b, result_hi, result_lo, div_by_zero, n);
        if (inject) begin
            extra_done = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            check("single_done", extra_done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        #1 rst = 1'b0;
        #1 cmp_en = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", result_hi, 0);
        check("rst_lo", result_lo, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        #2 rst = 1'b1;

        do_op(1'b0, 16'h0003, 16'hFFFC, 16'hFFFF, 16'hFFF4, 1'b0, 0);
        do_op(1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 0);
        do_op(1'b1, 16'h0005, 16'h0000, 16'h0005, 16'hFFFF, 1'b1, 0);
        do_op(1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0004, 1'b0, 0);
        do_op(1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 0);
        do_op(1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 0);
        do_op(1'b1, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 0);
        do_op(1'b1, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 1'b0, 0);
        do_op(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        do_op(1'b0, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000, 1'b0, 0);
        do_op(1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 0);
        do_op(1'b1, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2, 1'b0, 0);
        do_op(1'b0, 16'h0010, 16'h0010, 16'h0000, 16'h0100, 1'b0, 1);

        // Reset in the middle of a multiply: outputs clear at once, no done.
        @(negedge clk);
        op = 1'b0; operand_a = 16'h1234; operand_b = 16'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", result_hi, 0);
        check("arst_lo", result_lo, 0);
        check("arst_dbz", div_by_zero, 0);
        $display("reset during mul 1234 x 5678 -> busy=%0d hi=%h lo=%h", busy, result_hi, result_lo);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
        end
        do_op(1'b0, 16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, 1'b0, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
